alu_stream: RTL and testbench

Parametrised streaming ALU: a buffered operand FIFO feeds a 4-op ALU engine (ADD, SUB, multi-cycle MUL, DIV with divide-by-zero flag), which feeds a buffered result FIFO. Both sides use valid/ready handshakes with backpressure. This is the next-generation arithmetic path, replacing the fixed 4-bit, 8-entry pipeline. Results leave in strict input order.

---
 rtl/alu_stream_pkg.sv | 31 +++
 rtl/alu_stream_if.sv | 26 ++
 rtl/sync_fifo.sv | 42 ++++
 rtl/alu_stream.sv | 128 ++++++++++++
 tb/tb_alu_stream.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_stream_pkg.sv
// Shared types and field layout for the streaming ALU.
package alu_stream_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } op_t;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   // Operand word layout: {op, b, a}, a in the low W bits.
   localparam int OP_W = 2;

   function automatic int a_lsb(input int w);
      return 0;
   endfunction

   function automatic int b_lsb(input int w);
      return w;
   endfunction

   function automatic int op_lsb(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/alu_stream_if.sv
// Operand and result valid/ready streams of the ALU.
interface alu_stream_if
   import alu_stream_pkg::*;
#(
   parameter int W = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2*W+OP_W-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*W-1:0]        out_data;
   logic                  out_err;

   // Producer/consumer side (drives operands, accepts results).
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   // ALU side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;

   // Pointer update; storage is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/alu_stream.sv
// Streaming ALU: operand FIFO -> single-op engine -> result FIFO, in order.
module alu_stream
   import alu_stream_pkg::*;
#(
   parameter int W          = 4,
   parameter int DEPTH      = 8,
   parameter int MUL_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   alu_stream_if.slave             bus,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  in_level,
   output logic [$clog2(DEPTH):0]  out_level
);
   localparam int IW     = 2*W + OP_W;
   localparam int RW     = 2*W + 1;
   localparam int CW     = $clog2(MUL_CYCLES) + 1;
   localparam int OP_LSB = op_lsb(W);
   localparam int B_LSB  = b_lsb(W);

   logic          in_push, in_pop, in_full, in_empty;
   logic          out_push, out_pop, out_full, out_empty;
   logic [IW-1:0] in_head;
   logic [RW-1:0] out_head, res_word;

   sync_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_in_fifo (
      .clk(clk), .reset(reset),
      .push(in_push), .wdata(bus.in_data),
      .pop(in_pop), .rdata(in_head),
      .full(in_full), .empty(in_empty), .level(in_level)
   );

   sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_out_fifo (
      .clk(clk), .reset(reset),
      .push(out_push), .wdata(res_word),
      .pop(out_pop), .rdata(out_head),
      .full(out_full), .empty(out_empty), .level(out_level)
   );

   assign bus.in_ready  = reset && !in_full;
   assign in_push       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = !out_empty;
   assign out_pop       = bus.out_valid && bus.out_ready;
   // Zero the result port when empty so stale storage never shows after reset.
   assign bus.out_data  = out_empty ? '0 : out_head[2*W-1:0];
   assign bus.out_err   = !out_empty && out_head[2*W];

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   a_q, b_q;
   op_t            op_q, op_in;
   logic           start;

   // Only start when a result slot is free: the push at the end of EXEC
   // then can never hit a full result FIFO.
   assign start = !in_empty && !out_full;
   assign op_in = op_t'(in_head[OP_LSB +: OP_W]);
   assign busy  = (state == EXEC);

   // Engine state register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Engine next-state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)      state_nxt = EXEC;
         EXEC:    if (cnt == '0)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Engine outputs: pop operands on start, push result on last EXEC cycle.
   always_comb begin
      in_pop   = 1'b0;
      out_push = 1'b0;
      case (state)
         IDLE:    in_pop   = start;
         EXEC:    out_push = (cnt == '0);
         default: ;
      endcase
   end

   // Operand capture and latency countdown (cnt = remaining cycles - 1).
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (in_pop) begin
         a_q  <= in_head[W-1:0];
         b_q  <= in_head[B_LSB +: W];
         op_q <= op_in;
         cnt  <= (op_in == MUL) ? CW'(MUL_CYCLES - 1) : '0;
      end else if (busy && cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   logic [2*W-1:0] a_x, b_x, res;
   logic           err;
   assign a_x = {{W{1'b0}}, a_q};
   assign b_x = {{W{1'b0}}, b_q};

   // Arithmetic on the held operands; SUB is the exact difference in 2W bits.
   always_comb begin
      res = '0;
      err = 1'b0;
      case (op_q)
         ADD: res = a_x + b_x;
         SUB: res = a_x - b_x;
         MUL: res = a_x * b_x;
         DIV: begin
            if (b_q == '0) begin
               res = {a_q, {W{1'b1}}};
               err = 1'b1;
            end else begin
               res = {a_q % b_q, a_q / b_q};
            end
         end
         default: ;
      endcase
   end

   assign res_word = {err, res};
endmodule

// File: tb/tb_alu_stream.sv
// Directed and random checks of alu_stream against an in-order result model.
module tb_alu_stream;
   localparam int W          = 4;
   localparam int DEPTH      = 8;
   localparam int MUL_CYCLES = 3;
   localparam int LW         = $clog2(DEPTH) + 1;
   localparam int N_RAND     = 10000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          busy;
   logic [LW-1:0] in_level, out_level;
   int            n_vec = 0;
   int            n_mis = 0;
   int            cyc = 0;
   logic [2*W:0]  q[$];

   alu_stream_if #(.W(W)) bus ();

   alu_stream #(.W(W), .DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .busy(busy), .in_level(in_level), .out_level(out_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected {err, result} straight from the arithmetic definitions.
   function automatic logic [2*W:0] model(input int a, input int b, input int op);
      int   r;
      logic e;
      e = 1'b0;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a * b;
         default: begin
            if (b == 0) begin
               r = (a << W) | ((1 << W) - 1);
               e = 1'b1;
            end else begin
               r = ((a % b) << W) | (a / b);
            end
         end
      endcase
      return {e, r[2*W-1:0]};
   endfunction

   function automatic logic [2*W+1:0] pack(input int a, input int b, input int op);
      logic [W-1:0] aa, bb;
      logic [1:0]   oo;
      aa = a[W-1:0];
      bb = b[W-1:0];
      oo = op[1:0];
      return {oo, bb, aa};
   endfunction

   // Scoreboard: every result leaving must match the next expected one in order.
   always @(negedge clk) begin
      if (!reset) begin
         q.delete();
         check("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
      end else begin
         check("occupancy", int'(in_level) + int'(out_level) + int'(busy), q.size());
         check("in_ready_vs_level", {31'd0, bus.in_ready}, {31'd0, (in_level < LW'(DEPTH))});
         if (q.size() == 0) check("out_valid_no_pending", {31'd0, bus.out_valid}, 32'd0);
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            check("result", {bus.out_err, bus.out_data}, q[0]);
            void'(q.pop_front());
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.in_data[W-1:0], bus.in_data[2*W-1:W], bus.in_data[2*W+1:2*W]));
      end
   end

   // Offer one word and wait for it to be accepted; c0 = cycle of accepting edge.
   task automatic send(input int a, input int b, input int op, output int c0);
      logic ok;
      ok = 1'b0;
      @(posedge clk); #1;
      bus.in_data  = pack(a, b, op);
      bus.in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      c0 = cyc;
      bus.in_valid = 1'b0;
   endtask

   // Wait for the next result; report latency and EXEC cycles seen.
   task automatic wait_result(input int c0, output int lat, output logic [2*W-1:0] d,
                              output logic e, output int nbusy);
      logic got;
      got = 1'b0;
      nbusy = 0;
      lat = -1;
      d = '0;
      e = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            lat = cyc - c0;
            d = bus.out_data;
            e = bus.out_err;
         end else if (busy) begin
            nbusy++;
         end
      end
      if (!got) check("result_timeout", 32'd0, 32'd1);
   endtask

   // Global bound so the run always ends.
   initial begin
      #(950000);
      $display("FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int             c0, lat, nb, idx, got, seen, sent;
      logic [2*W-1:0] d;
      logic           e, fired;
      int             ra, rb, rop;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_in_level", in_level, 32'd0);
      check("reset_out_level", out_level, 32'd0);
      check("reset_out_data", bus.out_data, 32'd0);
      check("reset_out_err", {31'd0, bus.out_err}, 32'd0);
      check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

      // Single ops with literal expectations
      send(9, 8, 0, c0);
      wait_result(c0, lat, d, e, nb);
      check("add_data", d, 32'h11);
      check("add_err", {31'd0, e}, 32'd0);
      check("add_latency", lat, 32'd2);

      send(3, 5, 1, c0);
      wait_result(c0, lat, d, e, nb);
      check("sub_data", d, 32'hFE);

      send(15, 15, 2, c0);
      wait_result(c0, lat, d, e, nb);
      check("mul_data", d, 32'hE1);
      check("mul_latency", lat, 32'd4);
      check("mul_busy_cycles", nb, 32'd3);

      send(13, 4, 3, c0);
      wait_result(c0, lat, d, e, nb);
      check("div_data", d, 32'h13);
      check("div_err", {31'd0, e}, 32'd0);

      send(7, 0, 3, c0);
      wait_result(c0, lat, d, e, nb);
      check("div0_data", d, 32'h7F);
      check("div0_err", {31'd0, e}, 32'd1);

      // Backpressure: 20 words offered, result side stalled
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         bus.in_valid = (idx < 20);
         bus.in_data  = pack(idx, 2, 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("bp_accepted", idx, 32'd16);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_in_level", in_level, 32'd8);
      check("bp_out_level", out_level, 32'd8);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 120 && got < 16; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            check("bp_order", {bus.out_err, bus.out_data}, 32'(got + 2));
            got++;
         end
      end
      check("bp_count", got, 32'd16);
      repeat (3) @(negedge clk);
      check("bp_no_extra", {31'd0, bus.out_valid}, 32'd0);

      // Reset during the second MUL cycle discards the op
      send(3, 5, 2, c0);
      @(posedge clk);
      @(posedge clk); #1;
      check("mid_exec_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_in_level", in_level, 32'd0);
      check("mid_rst_out_level", out_level, 32'd0);
      check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_out_data", bus.out_data, 32'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check("mid_rst_no_result", seen, 32'd0);
      send(1, 1, 0, c0);
      wait_result(c0, lat, d, e, nb);
      check("post_rst_add", d, 32'h02);
      check("post_rst_latency", lat, 32'd2);

      // Random op mix with throttling on both sides
      sent = 0;
      fired = 1'b1;
      for (int k = 0; k < 80000 && sent < N_RAND; k++) begin
         @(posedge clk); #1;
         if (fired) begin
            ra  = $urandom_range(0, 15);
            rb  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
            rop = $urandom_range(0, 3);
            bus.in_data = pack(ra, rb, rop);
         end
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ((cyc / 64) % 8 == 7) ? 1'b0 : ($urandom_range(0, 4) != 0);
         @(negedge clk);
         fired = bus.in_valid && bus.in_ready;
         if (fired) sent++;
      end
      check("rand_sent", sent, N_RAND);
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 200 && (q.size() != 0 || busy || in_level != 0); k++)
         @(negedge clk);
      check("drain_pending", q.size(), 32'd0);
      check("drain_out_level", out_level, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
